// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, instruction formats and the
// opcode-to-format classifier used by the decode stage.
package rv32i_pkg;

  localparam int RV_XLEN       = 32;
  localparam int RV_REG_ADDR_W = 5;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    fmt_e fmt;
    logic illegal;
  } op_class_t;

  // Unknown opcodes are tagged illegal but still get a format (I) so the
  // packet can flow to execute and trap there.
  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t c;
    c.fmt     = FMT_I;
    c.illegal = 1'b0;
    case (opcode)
      OP:                                   c.fmt = FMT_R;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: c.fmt = FMT_I;
      STORE:                                c.fmt = FMT_S;
      BRANCH:                               c.fmt = FMT_B;
      LUI, AUIPC:                           c.fmt = FMT_U;
      JAL:                                  c.fmt = FMT_J;
      default:                              c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: selects and sign-extends the
// immediate field of an instruction according to its format.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7]        instr,
  input  fmt_e               fmt,
  output logic [RV_XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: registers the fetched instruction, drives the
// register-file read addresses and assembles the operand packet for execute.
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN       = RV_XLEN,
  parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_read1,
  output logic [REG_ADDR_W-1:0] rf_read2,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [XLEN-1:0]       out_imm,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic [6:0]            out_opcode,
  output logic [3:0]            out_funct,
  output logic [2:0]            out_fmt,
  output logic                  out_illegal
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer holding valid keeps its payload stable until that edge;
  // in_ready never depends on in_valid, out_valid never depends on out_ready.

  logic                  s1_valid;
  logic [XLEN-1:0]       s1_pc;
  logic [XLEN-1:0]       s1_imm;
  logic [REG_ADDR_W-1:0] s1_rs1;
  logic [REG_ADDR_W-1:0] s1_rs2;
  logic [REG_ADDR_W-1:0] s1_rd;
  logic                  s1_rd_we;
  logic [6:0]            s1_opcode;
  logic [3:0]            s1_funct;
  fmt_e                  s1_fmt;
  logic                  s1_illegal;

  logic                  hit1, hit2;
  logic [XLEN-1:0]       byp1, byp2;

  op_class_t             dec;
  logic [XLEN-1:0]       dec_imm_raw;
  logic [XLEN-1:0]       dec_imm;
  logic                  dec_rd_we;

  assign in_ready = !rst && !flush && (!s1_valid || out_ready);

  // While stalled the held sources are re-read so late writeback is picked up.
  assign rf_read1 = in_ready ? in_instr[19:15] : s1_rs1;
  assign rf_read2 = in_ready ? in_instr[24:20] : s1_rs2;

  assign dec = classify(in_instr[6:0]);

  rv32i_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (dec.fmt),
    .imm   (dec_imm_raw)
  );

  assign dec_imm   = dec.illegal ? '0 : dec_imm_raw;
  assign dec_rd_we = !dec.illegal && (dec.fmt != FMT_S) && (dec.fmt != FMT_B)
                     && (in_instr[11:7] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_pc      <= '0;
      s1_imm     <= '0;
      s1_rs1     <= '0;
      s1_rs2     <= '0;
      s1_rd      <= '0;
      s1_rd_we   <= 1'b0;
      s1_opcode  <= '0;
      s1_funct   <= '0;
      s1_fmt     <= FMT_R;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pc      <= in_pc;
        s1_imm     <= dec_imm;
        s1_rs1     <= in_instr[19:15];
        s1_rs2     <= in_instr[24:20];
        s1_rd      <= in_instr[11:7];
        s1_rd_we   <= dec_rd_we;
        s1_opcode  <= in_instr[6:0];
        s1_funct   <= {in_instr[30], in_instr[14:12]};
        s1_fmt     <= dec.fmt;
        s1_illegal <= dec.illegal;
      end
    end
  end

  // The register file returns pre-write data when a read and a write hit the
  // same register on one edge; capture the written value to cover that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
      byp1 <= '0;
      byp2 <= '0;
    end else begin
      hit1 <= wb_we && (wb_rd != '0) && (wb_rd == rf_read1);
      hit2 <= wb_we && (wb_rd != '0) && (wb_rd == rf_read2);
      byp1 <= wb_data;
      byp2 <= wb_data;
    end
  end

  always_comb begin
    out_rs1_val = rf_data1;
    out_rs2_val = rf_data2;
    if (s1_rs1 == '0)  out_rs1_val = '0;
    else if (hit1)     out_rs1_val = byp1;
    if (s1_rs2 == '0)  out_rs2_val = '0;
    else if (hit2)     out_rs2_val = byp2;
  end

  assign out_valid   = s1_valid;
  assign out_pc      = s1_pc;
  assign out_imm     = s1_imm;
  assign out_rd      = s1_rd;
  assign out_rd_we   = s1_rd_we;
  assign out_opcode  = s1_opcode;
  assign out_funct   = s1_funct;
  assign out_fmt     = s1_fmt;
  assign out_illegal = s1_illegal;

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Instruction-decode stage that sits directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses. Because the register file has a registered read, operands arrive one clock later.
- Bypasses same-edge writeback data, forces x0 to zero, and emits a decoded packet (operands, immediate, format, control) to execute over a second valid/ready handshake.

Parameters:
XLEN, 32, data/instruction/PC width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  fetch offers an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  XLEN  instruction word
in_pc  input  XLEN  instruction PC
flush  input  1  kill held and incoming instructions
rf_read1  output  REG_ADDR_W  register-file read port 1 address
rf_read2  output  REG_ADDR_W  register-file read port 2 address
rf_data1  input  XLEN  register-file read data 1, valid one cycle after address
rf_data2  input  XLEN  register-file read data 2
wb_we  input  1  writeback write enable (same signal driving the register file)
wb_rd  input  REG_ADDR_W  writeback destination
wb_data  input  XLEN  writeback data
out_valid  output  1  decoded packet valid
out_ready  input  1  execute accepts packet
out_pc  output  XLEN  PC of packet
out_rs1_val  output  XLEN  operand 1
out_rs2_val  output  XLEN  operand 2
out_imm  output  XLEN  sign-extended immediate
out_rd  output  REG_ADDR_W  destination register
out_rd_we  output  1  packet writes rd
out_opcode  output  7  instr[6:0]
out_funct  output  4  {instr[30], instr[14:12]}
out_fmt  output  3  R/I/S/B/U/J encoding
out_illegal  output  1  opcode not in RV32I base set

Behaviour:
- Reset (async, rst=1): s1_valid=0 and both bypass hit flags=0. All out_* registers are 0 (out_fmt=R). in_ready=0 while rst is high.
- in_ready = !rst && !flush && (!s1_valid || out_ready).
- Accept: an edge with in_valid && in_ready loads the S1 register with pc, instr fields and decoded controls, and sets s1_valid=1.
- Edge with in_ready && !in_valid: s1_valid becomes 0.
- No edge with in_ready low changes S1.
- Latency: an instruction accepted at edge N has out_valid=1 with correct operands during cycle N+1. Throughput is 1/cycle when out_ready stays high.
- Address mux (combinational):
  - rf_read1 = in_ready ? in_instr[19:15] : s1_rs1.
  - rf_read2 = in_ready ? in_instr[24:20] : s1_rs2.
  - During a stall the register file therefore re-reads the held sources every cycle.
- Writeback bypass: at every edge, hitK <= wb_we && wb_rd!=0 && wb_rd==rf_readK, and bypK <= wb_data. This covers the register file returning old data when a read and a write hit the same register on the same edge.
- Operand select: out_rsK_val = (s1_rsK==0) ? 0 : hitK ? bypK : rf_dataK.
  - x0 always reads as 0, independent of register-file contents.
- Immediate per format (I, S, B, U, J), sign-extended from instr[31]. B and J immediates have bit 0 = 0. R-format immediate = 0.
- Format from opcode:
  - R: 0110011
  - I: 0010011, 0000011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
- Any other opcode: out_illegal=1, out_rd_we=0, out_fmt=I, out_imm=0. The packet still flows so that execute can trap.
- out_rd_we = 0 for S, B, illegal, or rd==0; otherwise 1.
- Flush: an edge with flush=1 clears s1_valid. No instruction is accepted on that edge. out_valid is low in the following cycle.
- Flush and rst together: rst dominates.
- out_* fields are stable while out_valid && !out_ready. Only the operands may change, and only to reflect newer writeback to the held sources.
- Backpressure: holding out_ready=0 for any number of cycles loses and duplicates nothing.

Decomposition:
- Package rv32i_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM)
  - fmt_e enum (3-bit: R, I, S, B, U, J)
  - XLEN and register-index widths
- Sub-module rv32i_imm_gen: combinational, instr + fmt -> imm. Reused later by the branch unit.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 -> out_valid=0 and in_ready=0 immediately. One cycle after release, in_ready=1 and outputs are all-zero.
- Back-to-back: ADDI x1,x0,5 (0x00500093), then ADD x3,x1,x2 with RF x2=7 and x1 written 5 on the accept edge -> packet 1 has imm=5 and rs1_val=0. Packet 2 has rs1_val=5 via bypass and rs2_val=7, on consecutive cycles.
- Stall: out_ready=0 for 4 cycles while writeback writes x2=0xDEADBEEF on cycle 2 -> in_ready=0 throughout, and out_rs2_val changes to 0xDEADBEEF. The packet is consumed once when out_ready rises.
- Immediates:
  - SW with offset -4 -> imm=0xFFFFFFFC, rd_we=0
  - BEQ with offset -8 -> imm=0xFFFFFFF8
  - LUI 0x12345 -> imm=0x12345000
  - JAL with offset 2048 -> imm=0x00000800
- Illegal and x0: opcode 0x7F -> out_illegal=1, rd_we=0. ADD x0,x5,x6 -> rd_we=0. Any read of x0 with RF[0]=garbage -> operand 0.
- Flush: flush asserted on the edge an instruction is offered, with one held in S1 -> neither appears (out_valid=0 the next cycle). The next instruction after flush deasserts is delivered normally.
